// File: rtl/writeback_stage_if.sv
// Bus between the MEM/WB pipeline register and the writeback stage.
// The master side (MEM stage or bench) drives the MEM slot and the stall/flush
// controls. The slave side (writeback_stage) returns the registered
// register-file write port and the retire counter.
interface writeback_stage_if #(
  parameter int WordLen   = 32,
  parameter int WordCount = 5
);
  logic                 memValid;
  logic                 stall;
  logic                 flush;
  logic                 memRegWrite;
  logic [WordCount-1:0] memRd;
  logic [1:0]           memWbSel;
  logic [WordLen-1:0]   memAluResult;
  logic [WordLen-1:0]   memLoadData;
  logic [WordLen-1:0]   memPcPlus4;
  logic [WordLen-1:0]   memImm;
  logic [2:0]           memFunct3;

  logic                 regWrite;
  logic [WordCount-1:0] writeRegister;
  logic [WordLen-1:0]   writeData;
  logic                 wbValid;
  logic [31:0]          retireCount;

  modport master (
    output memValid, stall, flush, memRegWrite, memRd, memWbSel,
           memAluResult, memLoadData, memPcPlus4, memImm, memFunct3,
    input  regWrite, writeRegister, writeData, wbValid, retireCount
  );

  modport slave (
    input  memValid, stall, flush, memRegWrite, memRd, memWbSel,
           memAluResult, memLoadData, memPcPlus4, memImm, memFunct3,
    output regWrite, writeRegister, writeData, wbValid, retireCount
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: registers the selected result of the MEM slot and presents
// it to the register file one cycle later, which writes on the falling edge.
// It also counts retired instructions.
// Optional feature macro WB_LOAD_EXT_EN: when defined, loads are
// byte/halfword extracted and extended according to funct3 and the address
// offset. When undefined, load data is passed through unchanged.
module writeback_stage #(
  parameter int WordLen   = 32,
  parameter int WordCount = 5
) (
  input logic              clk,
  input logic              reset,
  writeback_stage_if.slave wb
);

  logic                 regWriteReg, regWriteNext;
  logic [WordCount-1:0] writeRegisterReg, writeRegisterNext;
  logic [WordLen-1:0]   writeDataReg, writeDataNext;
  logic                 wbValidReg, wbValidNext;
  logic [31:0]          retireCountReg, retireCountNext;

  logic [WordLen-1:0]   loadValue;
  logic [WordLen-1:0]   selValue;

`ifdef WB_LOAD_EXT_EN
  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  // Pick the addressed byte/halfword lane and extend it as funct3 asks.
  always_comb begin
    byteLane  = 8'(wb.memLoadData >> {wb.memAluResult[1:0], 3'b000});
    halfLane  = 16'(wb.memLoadData >> {wb.memAluResult[1], 4'b0000});
    loadValue = wb.memLoadData;
    case (wb.memFunct3)
      3'b000:  loadValue = {{(WordLen-8){byteLane[7]}}, byteLane};
      3'b100:  loadValue = {{(WordLen-8){1'b0}}, byteLane};
      3'b001:  loadValue = {{(WordLen-16){halfLane[15]}}, halfLane};
      3'b101:  loadValue = {{(WordLen-16){1'b0}}, halfLane};
      default: loadValue = wb.memLoadData;
    endcase
  end
`else
  // Without extension support a load writes back the raw memory word.
  assign loadValue = wb.memLoadData;
`endif

  // Writeback source multiplexer.
  always_comb begin
    selValue = wb.memAluResult;
    case (wb.memWbSel)
      2'b00:   selValue = wb.memAluResult;
      2'b01:   selValue = loadValue;
      2'b10:   selValue = wb.memPcPlus4;
      default: selValue = wb.memImm;
    endcase
  end

  // Next state: flush kills the slot but keeps the data path, stall holds
  // everything, otherwise the MEM slot is captured.
  always_comb begin
    regWriteNext      = regWriteReg;
    writeRegisterNext = writeRegisterReg;
    writeDataNext     = writeDataReg;
    wbValidNext       = wbValidReg;
    retireCountNext   = retireCountReg;
    if (wb.flush) begin
      wbValidNext  = 1'b0;
      regWriteNext = 1'b0;
    end else if (!wb.stall) begin
      wbValidNext       = wb.memValid;
      writeRegisterNext = wb.memRd;
      writeDataNext     = selValue;
      regWriteNext      = wb.memValid & wb.memRegWrite & (wb.memRd != '0);
      if (wb.memValid) begin
        retireCountNext = retireCountReg + 32'd1;
      end
    end
  end

  // Output registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      regWriteReg      <= 1'b0;
      writeRegisterReg <= '0;
      writeDataReg     <= '0;
      wbValidReg       <= 1'b0;
      retireCountReg   <= 32'd0;
    end else begin
      regWriteReg      <= regWriteNext;
      writeRegisterReg <= writeRegisterNext;
      writeDataReg     <= writeDataNext;
      wbValidReg       <= wbValidNext;
      retireCountReg   <= retireCountNext;
    end
  end

  assign wb.regWrite      = regWriteReg;
  assign wb.writeRegister = writeRegisterReg;
  assign wb.writeData     = writeDataReg;
  assign wb.wbValid       = wbValidReg;
  assign wb.retireCount   = retireCountReg;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios followed by
// randomized traffic, compared against a behavioural model of the stage.
module tb_writeback_stage;
  localparam int WordLen   = 32;
  localparam int WordCount = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  writeback_stage_if #(.WordLen(WordLen), .WordCount(WordCount)) bus ();

  writeback_stage #(.WordLen(WordLen), .WordCount(WordCount)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic        expValid;
  logic        expRegWrite;
  logic [4:0]  expRd;
  logic [31:0] expData;
  logic [31:0] expRetire;

  // Register file sink, written on the falling edge like the real one.
  logic [31:0] regFile [32];
  always @(negedge clk) begin
    if (bus.regWrite) regFile[bus.writeRegister] = bus.writeData;
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] extLoad(input logic [31:0] d, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [31:0] b, h, ext;
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'b000:  ext = (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'b100:  ext = b;
      3'b001:  ext = (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  ext = h;
      default: ext = d;
    endcase
`ifdef WB_LOAD_EXT_EN
    return ext;
`else
    return (ext == ext) ? d : d;
`endif
  endfunction

  function automatic logic [31:0] pickValue();
    case (bus.memWbSel)
      2'd0:    return bus.memAluResult;
      2'd1:    return extLoad(bus.memLoadData, bus.memFunct3, bus.memAluResult[1:0]);
      2'd2:    return bus.memPcPlus4;
      default: return bus.memImm;
    endcase
  endfunction

  // What one rising edge should do, given the inputs currently applied.
  task automatic modelEdge();
    if (reset) begin
      expValid = 0; expRegWrite = 0; expRd = 0; expData = 0; expRetire = 0;
    end else if (bus.flush) begin
      expValid = 0; expRegWrite = 0;
    end else if (!bus.stall) begin
      expValid    = bus.memValid;
      expRd       = bus.memRd;
      expData     = pickValue();
      expRegWrite = bus.memValid && bus.memRegWrite && (bus.memRd != 0);
      if (bus.memValid) expRetire = expRetire + 1;
    end
  endtask

  task automatic compareAll(input string tag);
    checkVal({tag, ".wbValid"},  64'(bus.wbValid),       64'(expValid));
    checkVal({tag, ".regWrite"}, 64'(bus.regWrite),      64'(expRegWrite));
    checkVal({tag, ".rd"},       64'(bus.writeRegister), 64'(expRd));
    checkVal({tag, ".data"},     64'(bus.writeData),     64'(expData));
    checkVal({tag, ".retire"},   64'(bus.retireCount),   64'(expRetire));
  endtask

  // One clock: model follows the rising edge, DUT sampled on the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    compareAll(tag);
  endtask

  task automatic idleInputs();
    bus.memValid = 0; bus.stall = 0; bus.flush = 0; bus.memRegWrite = 0;
    bus.memRd = 0; bus.memWbSel = 0; bus.memAluResult = 0; bus.memLoadData = 0;
    bus.memPcPlus4 = 0; bus.memImm = 0; bus.memFunct3 = 0;
  endtask

  task automatic driveLoad(input logic [2:0] f3, input logic [1:0] off);
    bus.memValid = 1; bus.memRegWrite = 1; bus.memRd = 5'd7; bus.memWbSel = 2'b01;
    bus.memLoadData = 32'h80F1_7F82; bus.memFunct3 = f3;
    bus.memAluResult = {30'h400, off};
  endtask

  task automatic randomInputs();
    bus.memValid     = ($urandom_range(0, 3) != 0);
    bus.memRegWrite  = ($urandom_range(0, 3) != 0);
    bus.memRd        = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    bus.memWbSel     = 2'($urandom);
    bus.memAluResult = $urandom;
    bus.memLoadData  = $urandom;
    bus.memPcPlus4   = $urandom;
    bus.memImm       = $urandom;
    bus.memFunct3    = 3'($urandom);
    bus.stall        = ($urandom_range(0, 4) == 0);
    bus.flush        = ($urandom_range(0, 7) == 0);
    reset            = ($urandom_range(0, 39) == 0);
  endtask

  initial begin
    logic [31:0] sb, zb, sh;
    for (int i = 0; i < 32; i++) regFile[i] = 32'hDEAD_BEEF;
    expValid = 1; expRegWrite = 1; expRd = 5'h1F; expData = '1; expRetire = '1;
    idleInputs();
    reset = 1;
    @(negedge clk);

    // Reset held for two cycles clears every output.
    step("reset1");
    step("reset2");
    checkVal("resetRetire", 64'(bus.retireCount), 64'd0);
    reset = 0;

    // ALU result written to x3.
    bus.memValid = 1; bus.memRegWrite = 1; bus.memRd = 5'd3; bus.memWbSel = 2'b00;
    bus.memAluResult = 32'h0000_002A;
    step("alu");
    checkVal("aluRegWrite", 64'(bus.regWrite), 64'd1);
    checkVal("aluRd", 64'(bus.writeRegister), 64'd3);
    checkVal("aluData", 64'(bus.writeData), 64'h2A);
    checkVal("aluRetire", 64'(bus.retireCount), 64'd1);
    #1;
    checkVal("regFileX3", 64'(regFile[3]), 64'h2A);

    // Load extension cases.
`ifdef WB_LOAD_EXT_EN
    sb = 32'hFFFF_FF82; zb = 32'h0000_0082; sh = 32'hFFFF_80F1;
`else
    sb = 32'h80F1_7F82; zb = 32'h80F1_7F82; sh = 32'h80F1_7F82;
`endif
    driveLoad(3'b000, 2'd0); step("lb");
    checkVal("lbData", 64'(bus.writeData), 64'(sb));
    driveLoad(3'b100, 2'd0); step("lbu");
    checkVal("lbuData", 64'(bus.writeData), 64'(zb));
    driveLoad(3'b001, 2'd2); step("lh");
    checkVal("lhData", 64'(bus.writeData), 64'(sh));

    // Write to x0 is captured but never asserts regWrite.
    bus.memRd = 5'd0; bus.memWbSel = 2'b10; bus.memPcPlus4 = 32'h0000_1004;
    step("x0");
    checkVal("x0RegWrite", 64'(bus.regWrite), 64'd0);
    checkVal("x0Valid", 64'(bus.wbValid), 64'd1);
    checkVal("x0Retire", 64'(bus.retireCount), 64'd5);

    // Stall for three cycles with changing MEM inputs.
    bus.memRd = 5'd9; bus.memWbSel = 2'b11; bus.memImm = 32'h1234_5678;
    step("preStall");
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      bus.memImm = $urandom; bus.memRd = 5'($urandom);
      step("stall");
      checkVal("stallData", 64'(bus.writeData), 64'h1234_5678);
      checkVal("stallRetire", 64'(bus.retireCount), 64'd6);
    end

    // Flush wins over stall.
    bus.flush = 1;
    step("stallFlush");
    checkVal("flushValid", 64'(bus.wbValid), 64'd0);
    checkVal("flushRegWrite", 64'(bus.regWrite), 64'd0);
    checkVal("flushData", 64'(bus.writeData), 64'h1234_5678);
    bus.flush = 0;

    // Reset while a write is held by stall.
    bus.stall = 0; bus.memRd = 5'd4; step("refill");
    bus.stall = 1; reset = 1;
    step("resetInStall");
    checkVal("rstStallRegWrite", 64'(bus.regWrite), 64'd0);
    checkVal("rstStallRetire", 64'(bus.retireCount), 64'd0);
    reset = 0; bus.stall = 0;

    // Retire counter wraps after preloading it to all ones.
    bus.stall = 1;
    force dut.retireCountReg = 32'hFFFF_FFFF;
    #1;
    release dut.retireCountReg;
    #1;
    expRetire = 32'hFFFF_FFFF;
    checkVal("preloadRetire", 64'(bus.retireCount), 64'hFFFF_FFFF);
    bus.stall = 0; bus.memValid = 1;
    step("wrap");
    checkVal("wrapRetire", 64'(bus.retireCount), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      randomInputs();
      step("rand");
    end
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
